// File: rtl/mem_uart_ctrl.sv
// Arbitrates CPU accesses over a shared SRAM/UART data bus and buffers UART RX bytes in a local queue.
// Optional build macro MEMUART_TX_NONBLOCK_EN: posted UART TX writes (done right after the write strobe).
module mem_uart_ctrl #(
  parameter int                DATA_W         = 16,
  parameter int                ADDR_W         = 18,
  parameter int                RXQ_AW         = 4,
  parameter int                WAIT_CYCLES    = 1,
  parameter logic [ADDR_W-1:0] UART_DATA_ADDR = 18'h0BF00,
  parameter logic [ADDR_W-1:0] UART_STAT_ADDR = 18'h0BF01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] bus_data,
  output logic              ram_en_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              uart_rdn,
  output logic              uart_wrn,
  input  logic              uart_data_ready,
  input  logic              uart_tbre,
  input  logic              uart_tsre,
  output logic [RXQ_AW:0]   rxq_count
);

  localparam int                CNT_W   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  WAIT_LD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [RXQ_AW-1:0] PTR_ONE = RXQ_AW'(1);
  localparam logic [RXQ_AW:0]   CNT1    = (RXQ_AW + 1)'(1);
  localparam logic [RXQ_AW:0]   Q_FULL  = (RXQ_AW + 1)'(1 << RXQ_AW);

  typedef enum logic [3:0] {
    ST_IDLE, ST_RD_STROBE, ST_RD_CAPTURE, ST_WR_SETUP, ST_WR_STROBE, ST_WR_HOLD,
    ST_TX_SETUP, ST_TX_STROBE, ST_TX_WAIT_TBRE, ST_TX_WAIT_TSRE,
    ST_RX_STROBE, ST_RX_CAPTURE, ST_REG_RD, ST_REG_WR
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_bus_oe;
  logic              r_done;
  logic              r_is_pop;
  logic              r_ram_en_n, r_ram_oe_n, r_ram_we_n, r_uart_rdn, r_uart_wrn;
  logic [RXQ_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [RXQ_AW:0]   r_count;
  logic [7:0]        r_rxq_mem [2**RXQ_AW];
`ifdef MEMUART_TX_NONBLOCK_EN
  logic              r_tx_posted;
`endif

  logic w_full, w_nonempty, w_push;

  assign w_full     = (r_count == Q_FULL);
  assign w_nonempty = (r_count != '0);
  assign w_push     = (r_state == ST_RX_CAPTURE);

  assign ram_addr  = addr;
  assign bus_data  = r_bus_oe ? r_wdata : 'z;
  assign rdata     = r_rdata;
  assign done      = r_done;
  assign busy      = (r_state != ST_IDLE);
  assign ram_en_n  = r_ram_en_n;
  assign ram_oe_n  = r_ram_oe_n;
  assign ram_we_n  = r_ram_we_n;
  assign uart_rdn  = r_uart_rdn;
  assign uart_wrn  = r_uart_wrn;
  assign rxq_count = r_count;

  // NOTE: queue storage has no reset; clearing the pointers and count is enough to discard its contents.
  always_ff @(posedge clk) begin
    if (w_push) r_rxq_mem[r_wr_ptr] <= bus_data[7:0];
  end

  // NOTE: all state updates use non-blocking assignment so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_bus_oe   <= 1'b0;
      r_done     <= 1'b0;
      r_is_pop   <= 1'b0;
      r_ram_en_n <= 1'b1;
      r_ram_oe_n <= 1'b1;
      r_ram_we_n <= 1'b1;
      r_uart_rdn <= 1'b1;
      r_uart_wrn <= 1'b1;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
`ifdef MEMUART_TX_NONBLOCK_EN
      r_tx_posted <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (uart_data_ready && !w_full) begin
            r_state    <= ST_RX_STROBE;
            r_cnt      <= WAIT_LD;
            r_uart_rdn <= 1'b0;
          end else if (req) begin
            r_wdata <= wdata;
            if (addr == UART_DATA_ADDR && we) begin
`ifdef MEMUART_TX_NONBLOCK_EN
              if (r_tx_posted) begin
                r_state <= ST_TX_WAIT_TBRE;
              end else begin
                r_state  <= ST_TX_SETUP;
                r_bus_oe <= 1'b1;
              end
`else
              r_state  <= ST_TX_SETUP;
              r_bus_oe <= 1'b1;
`endif
            end else if (addr == UART_DATA_ADDR || addr == UART_STAT_ADDR) begin
              r_is_pop <= (addr == UART_DATA_ADDR);
              r_state  <= we ? ST_REG_WR : ST_REG_RD;
            end else if (we) begin
              r_state    <= ST_WR_SETUP;
              r_ram_en_n <= 1'b0;
              r_bus_oe   <= 1'b1;
            end else begin
              r_state    <= ST_RD_STROBE;
              r_cnt      <= WAIT_LD;
              r_ram_en_n <= 1'b0;
              r_ram_oe_n <= 1'b0;
            end
          end
        end
        // Enable and output-enable stay low through capture so the SRAM is still driving when sampled.
        ST_RD_STROBE: if (r_cnt == '0) r_state <= ST_RD_CAPTURE; else r_cnt <= r_cnt - CNT_ONE;
        ST_RD_CAPTURE: begin
          r_rdata    <= bus_data;
          r_ram_en_n <= 1'b1;
          r_ram_oe_n <= 1'b1;
          r_done     <= 1'b1;
          r_state    <= ST_IDLE;
        end
        ST_WR_SETUP: begin
          r_state    <= ST_WR_STROBE;
          r_cnt      <= WAIT_LD;
          r_ram_we_n <= 1'b0;
        end
        ST_WR_STROBE: begin
          if (r_cnt == '0) begin
            r_ram_we_n <= 1'b1;
            r_state    <= ST_WR_HOLD;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_WR_HOLD: begin
          r_ram_en_n <= 1'b1;
          r_bus_oe   <= 1'b0;
          r_done     <= 1'b1;
          r_state    <= ST_IDLE;
        end
        ST_TX_SETUP: begin
          r_state    <= ST_TX_STROBE;
          r_cnt      <= WAIT_LD;
          r_uart_wrn <= 1'b0;
        end
        ST_TX_STROBE: begin
          if (r_cnt == '0) begin
            r_uart_wrn <= 1'b1;
            r_bus_oe   <= 1'b0;
`ifdef MEMUART_TX_NONBLOCK_EN
            r_tx_posted <= 1'b1;
            r_done      <= 1'b1;
            r_state     <= ST_IDLE;
`else
            r_state     <= ST_TX_WAIT_TBRE;
`endif
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_TX_WAIT_TBRE: begin
          if (uart_tbre) begin
`ifdef MEMUART_TX_NONBLOCK_EN
            r_tx_posted <= 1'b0;
            r_bus_oe    <= 1'b1;
            r_state     <= ST_TX_SETUP;
`else
            r_state     <= ST_TX_WAIT_TSRE;
`endif
          end
        end
        ST_TX_WAIT_TSRE: begin
          if (uart_tsre) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_RX_STROBE: if (r_cnt == '0) r_state <= ST_RX_CAPTURE; else r_cnt <= r_cnt - CNT_ONE;
        ST_RX_CAPTURE: begin
          r_uart_rdn <= 1'b1;
          r_wr_ptr   <= r_wr_ptr + PTR_ONE;
          r_count    <= r_count + CNT1;
          r_state    <= ST_IDLE;
        end
        ST_REG_RD: begin
          if (!r_is_pop) begin
            r_rdata <= DATA_W'({w_full, w_nonempty, uart_tbre & uart_tsre});
          end else if (w_nonempty) begin
            r_rdata  <= DATA_W'(r_rxq_mem[r_rd_ptr]);
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count  <= r_count - CNT1;
          end else begin
            r_rdata <= '0;
          end
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        ST_REG_WR: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_uart_ctrl.sv
// Self-checking bench for mem_uart_ctrl: SRAM and UART device models on the shared bus plus a queue/array reference model.
`timescale 1ns/1ps
module tb_mem_uart_ctrl;

  localparam int          WAIT_CYCLES = 1;
  localparam int          P           = WAIT_CYCLES + 1;
  localparam int          DEPTH       = 16;
  localparam logic [17:0] UDATA       = 18'h0BF00;
  localparam logic [17:0] USTAT       = 18'h0BF01;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we  = 1'b0;
  logic [17:0] addr  = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        done, busy;
  logic [17:0] ram_addr;
  wire  [15:0] bus_data;
  logic        ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn;
  logic        uart_tbre = 1'b1;
  logic        uart_tsre = 1'b1;
  wire         uart_data_ready;
  logic [4:0]  rxq_count;

  int total = 0;
  int bad   = 0;

  // Device models: SRAM array, UART RX byte source, bus probe driver.
  logic [15:0] sram [0:255];
  logic [7:0]  ubuf [0:63];
  int          u_wr = 0;
  int          u_rd = 0;
  logic        dr_en = 1'b0;
  logic        probe_en = 1'b0;
  logic        prev_rdn = 1'b1;
  int          wrn_low = 0, we_low = 0, rdn_low = 0, done_cnt = 0;
  logic [15:0] tx_byte = '0;

  wire sram_drv = !ram_en_n && !ram_oe_n && ram_we_n;
  wire uart_drv = !uart_rdn;
  assign bus_data = sram_drv ? sram[ram_addr[7:0]] :
                    uart_drv ? {8'hEE, ubuf[u_rd % 64]} :
                    probe_en ? 16'h5A5A : 16'hzzzz;
  assign uart_data_ready = dr_en && (u_wr != u_rd);

  always @(posedge clk) begin
    if (!ram_en_n && !ram_we_n) sram[ram_addr[7:0]] <= bus_data;
  end

  always @(negedge clk) begin
    if (!prev_rdn && uart_rdn && (u_rd != u_wr)) u_rd <= u_rd + 1;
    prev_rdn <= uart_rdn;
    if (!uart_wrn) begin
      wrn_low <= wrn_low + 1;
      tx_byte <= bus_data;
    end
    if (!ram_we_n) we_low  <= we_low + 1;
    if (!uart_rdn) rdn_low <= rdn_low + 1;
    if (done)      done_cnt <= done_cnt + 1;
  end

  always #5 clk = ~clk;

  mem_uart_ctrl #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .busy(busy), .ram_addr(ram_addr), .bus_data(bus_data),
    .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn), .uart_data_ready(uart_data_ready),
    .uart_tbre(uart_tbre), .uart_tsre(uart_tsre), .rxq_count(rxq_count)
  );

  // Reference model state.
  logic [15:0] ref_mem [0:255];
  int          waddrs[$];
  logic [7:0]  rq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; lat = clock edges from acceptance to done, -1 on timeout.
  task automatic do_access(input logic w, input logic [17:0] a, input logic [15:0] d,
                           output logic [15:0] rd, output int lat);
    req = 1'b1; we = w; addr = a; wdata = d; lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n - 1;
        break;
      end
    end
    rd  = rdata;
    req = 1'b0;
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  task automatic wait_count(input int target, input string tag);
    for (int n = 0; n < 200; n++) begin
      if (rxq_count == 5'(target)) break;
      @(negedge clk);
    end
    check(tag, {27'd0, rxq_count}, target);
  endtask

  task automatic inject(input logic [7:0] b);
    ubuf[u_wr % 64] = b;
    u_wr++;
    rq.push_back(b);
  endtask

  initial begin
    logic [15:0] rd, d, exp;
    logic [7:0]  b;
    int          lat, snap, snap2, a, n_done, busy_gaps, held;

    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_strobes", {25'd0, ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn, done, busy}, 32'h7C);
    check("reset_rdata", {16'd0, rdata}, 32'd0);
    check("reset_rxq_count", {27'd0, rxq_count}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Seed one word for the post-reset read
    do_access(1'b1, 18'h00010, 16'h1234, rd, lat);
    ref_mem[8'h10] = 16'h1234; waddrs.push_back(8'h10);
    check("seed_wr_lat", lat, P + 2);

    // Reset in the middle of RD_STROBE
    snap = done_cnt;
    req = 1'b1; we = 1'b0; addr = 18'h00010;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_strobes", {25'd0, ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn, done, busy}, 32'h7C);
    probe_en = 1'b1;
    #1 check("midrst_bus_released", {16'd0, bus_data}, 32'h5A5A);
    probe_en = 1'b0;
    req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_cnt, snap);
    do_access(1'b0, 18'h00010, '0, rd, lat);
    check("post_rst_rd_data", {16'd0, rd}, 32'h1234);
    check("post_rst_rd_lat", lat, P + 1);

    // RAM write then readback
    snap = we_low;
    do_access(1'b1, 18'h00123, 16'hA5C3, rd, lat);
    ref_mem[8'h23] = 16'hA5C3; waddrs.push_back(8'h23);
    check("wr_lat", lat, P + 2);
    check("wr_we_n_low_cycles", we_low - snap, P);
    do_access(1'b0, 18'h00123, '0, rd, lat);
    check("rd_lat", lat, P + 1);
    check("rd_data", {16'd0, rd}, 32'hA5C3);

    // Three RX bytes then four pops (last on empty queue)
    dr_en = 1'b1;
    inject(8'h31); inject(8'h32); inject(8'h33);
    wait_count(3, "rx3_count");
    for (int i = 0; i < 4; i++) begin
      exp = (rq.size() > 0) ? {8'h00, rq.pop_front()} : 16'h0000;
      do_access(1'b0, UDATA, '0, rd, lat);
      check("pop_data", {16'd0, rd}, {16'd0, exp});
      check("pop_lat", lat, 1);
      check("pop_count", {27'd0, rxq_count}, rq.size());
    end

    // Fill the queue with one extra byte waiting in the UART
    uart_tbre = 1'b0; uart_tsre = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) inject(8'($urandom));
    wait_count(DEPTH, "full_count");
    snap = rdn_low;
    repeat (10) @(negedge clk);
    check("full_rdn_idle", rdn_low - snap, 0);
    check("full_count_stable", {27'd0, rxq_count}, DEPTH);
    held = (rq.size() > DEPTH) ? DEPTH : rq.size();
    exp  = {13'd0, held == DEPTH, held != 0, uart_tbre & uart_tsre};
    do_access(1'b0, USTAT, '0, rd, lat);
    check("full_status", {16'd0, rd}, {16'd0, exp});
    check("full_status_const", {16'd0, rd}, 32'h0006);
    do_access(1'b0, UDATA, '0, rd, lat);
    check("full_pop_data", {16'd0, rd}, {24'd0, rq.pop_front()});
    wait_count(DEPTH, "refill_count");
    while (rq.size() > 0) begin
      do_access(1'b0, UDATA, '0, rd, lat);
      check("drain_data", {16'd0, rd}, {24'd0, rq.pop_front()});
    end
    check("drained_count", {27'd0, rxq_count}, 32'd0);

    // Blocking TX with delayed tbre/tsre
    snap = wrn_low; busy_gaps = 0; n_done = -1;
    req = 1'b1; we = 1'b1; addr = UDATA; wdata = 16'h0041;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) begin
        n_done = n;
        break;
      end
      if (!busy) busy_gaps++;
      if (n == 6) uart_tbre = 1'b1;
      if (n == 9) uart_tsre = 1'b1;
    end
    req = 1'b0;
    check("tx_done_after_tsre", n_done, 10);
    check("tx_wrn_low_cycles", wrn_low - snap, P);
    check("tx_busy_throughout", busy_gaps, 0);
    check("tx_data", {16'd0, tx_byte}, 32'h0041);
    @(negedge clk);

    // RX and CPU request arrive together
    snap = done_cnt;
    inject(8'h5C);
    do_access(1'b0, 18'h00123, '0, rd, lat);
    check("prio_lat", lat, 2 * P + 3);
    check("prio_rd_data", {16'd0, rd}, 32'hA5C3);
    check("prio_rx_count", {27'd0, rxq_count}, rq.size());
    repeat (3) @(negedge clk);
    check("prio_single_done", done_cnt - snap, 1);

    // Randomised mix against the reference model
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 6))
        0: begin
          a = $urandom_range(0, 255); d = 16'($urandom);
          do_access(1'b1, 18'(a), d, rd, lat);
          ref_mem[a] = d; waddrs.push_back(a);
          check("rnd_wr_lat", lat, P + 2);
        end
        1: begin
          a = waddrs[$urandom_range(0, waddrs.size() - 1)];
          do_access(1'b0, 18'(a), '0, rd, lat);
          check("rnd_rd_data", {16'd0, rd}, {16'd0, ref_mem[a]});
          check("rnd_rd_lat", lat, P + 1);
        end
        2: begin
          if (rq.size() < DEPTH) begin
            inject(8'($urandom));
            wait_count(rq.size(), "rnd_rx_count");
          end
        end
        3: begin
          exp = (rq.size() > 0) ? {8'h00, rq.pop_front()} : 16'h0000;
          do_access(1'b0, UDATA, '0, rd, lat);
          check("rnd_pop_data", {16'd0, rd}, {16'd0, exp});
          check("rnd_pop_count", {27'd0, rxq_count}, rq.size());
        end
        4: begin
          exp = {13'd0, rq.size() == DEPTH, rq.size() != 0, 1'b1};
          do_access(1'b0, USTAT, '0, rd, lat);
          check("rnd_status", {16'd0, rd}, {16'd0, exp});
          check("rnd_status_lat", lat, 1);
        end
        5: begin
          d = 16'($urandom_range(0, 255));
          snap2 = wrn_low;
          do_access(1'b1, UDATA, d, rd, lat);
          check("rnd_tx_lat", lat, P + 3);
          check("rnd_tx_data", {16'd0, tx_byte}, {16'd0, d});
          check("rnd_tx_wrn", wrn_low - snap2, P);
        end
        default: begin
          snap2 = wrn_low + we_low;
          do_access(1'b1, USTAT, 16'($urandom), rd, lat);
          check("rnd_statwr_lat", lat, 1);
          check("rnd_statwr_nobus", wrn_low + we_low - snap2, 0);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
